// File: rtl/bypass_pkg.sv
// Shared encodings and default sizing for the operand bypass network.
package bypass_pkg;

  localparam int unsigned DataWDef = 32;
  localparam int unsigned RegAwDef = 5;
  localparam int unsigned DepthDef = 2;
  localparam int unsigned NrdDef   = 2;

  // Forwarding source codes reported per read port.
  localparam logic [1:0] SelRf   = 2'd0;
  localparam logic [1:0] SelE0   = 2'd1;
  localparam logic [1:0] SelE1   = 2'd2;
  localparam logic [1:0] SelDeep = 2'd3;

  // Map a history index to its source code; everything past entry 1 shares one code.
  function automatic logic [1:0] sel_code(input int unsigned idx);
    if (idx == 0) begin
      return SelE0;
    end else if (idx == 1) begin
      return SelE1;
    end else begin
      return SelDeep;
    end
  endfunction

endpackage

// File: rtl/bypass_match.sv
// One read port: priority match against write history, operand select and load-use hazard.
module bypass_match
  import bypass_pkg::*;
#(
  parameter int unsigned DATA_W = DataWDef,
  parameter int unsigned REG_AW = RegAwDef,
  parameter int unsigned DEPTH  = DepthDef
) (
  input  logic [REG_AW-1:0]        rd_addr_i,
  input  logic [DATA_W-1:0]        rf_data_i,
  input  logic [DEPTH-1:0]         hist_valid_i,
  input  logic [DEPTH-1:0]         hist_load_i,
  input  logic [DEPTH*REG_AW-1:0]  hist_addr_i,
  input  logic [DEPTH*DATA_W-1:0]  hist_data_i,
  output logic [DATA_W-1:0]        rd_data_o,
  output logic [1:0]               fwd_sel_o,
  output logic                     hazard_o
);

  logic found;

  // Youngest valid, non-pending match wins; a pending load in entry 0 raises a hazard instead.
  always_comb begin
    rd_data_o = rf_data_i;
    fwd_sel_o = SelRf;
    hazard_o  = 1'b0;
    found     = 1'b0;
    if (rd_addr_i != '0) begin
      hazard_o = hist_valid_i[0] && hist_load_i[0] &&
                 (hist_addr_i[0 +: REG_AW] == rd_addr_i);
      for (int unsigned i = 0; i < DEPTH; i++) begin
        if (!found && hist_valid_i[i] && !hist_load_i[i] &&
            (hist_addr_i[i*REG_AW +: REG_AW] == rd_addr_i)) begin
          found     = 1'b1;
          rd_data_o = hist_data_i[i*DATA_W +: DATA_W];
          fwd_sel_o = sel_code(i);
        end
      end
    end
  end

endmodule

// File: rtl/bypass_unit.sv
// Operand bypass: shift register of in-flight writes plus per-port forwarding muxes.
module bypass_unit
  import bypass_pkg::*;
#(
  parameter int unsigned DATA_W = DataWDef,
  parameter int unsigned REG_AW = RegAwDef,
  parameter int unsigned DEPTH  = DepthDef,
  parameter int unsigned NRD    = NrdDef
) (
  input  logic                    clk_i,
  input  logic                    rst_n_i,
  input  logic                    wr_en_i,
  input  logic                    wr_load_i,
  input  logic [REG_AW-1:0]       wr_addr_i,
  input  logic [DATA_W-1:0]       wr_data_i,
  input  logic [DATA_W-1:0]       ld_data_i,
  input  logic                    stall_i,
  input  logic                    flush_i,
  input  logic [NRD*REG_AW-1:0]   rd_addr_i,
  input  logic [NRD*DATA_W-1:0]   rf_data_i,
  output logic [NRD*DATA_W-1:0]   rd_data_o,
  output logic [NRD*2-1:0]        fwd_sel_o,
  output logic                    hazard_o,
  output logic [15:0]             fwd_cnt_o
);

  logic [DEPTH-1:0]        valid_q, valid_d;
  logic [DEPTH-1:0]        load_q, load_d;
  logic [DEPTH*REG_AW-1:0] addr_q, addr_d;
  logic [DEPTH*DATA_W-1:0] data_q, data_d;
  logic [15:0]             cnt_q, cnt_d;
  logic [NRD-1:0]          port_hazard;
  logic                    any_fwd;

  // History next state: flush beats stall beats shift.
  always_comb begin
    valid_d = valid_q;
    load_d  = load_q;
    addr_d  = addr_q;
    data_d  = data_q;
    if (flush_i) begin
      valid_d = '0;
      load_d  = '0;
    end else if (!stall_i) begin
      // r0 writes are never tracked so they can never be forwarded.
      valid_d[0]              = wr_en_i && (wr_addr_i != '0);
      load_d[0]               = wr_load_i && wr_en_i && (wr_addr_i != '0);
      addr_d[0 +: REG_AW]     = wr_addr_i;
      data_d[0 +: DATA_W]     = wr_data_i;
      for (int unsigned i = 1; i < DEPTH; i++) begin
        valid_d[i]                  = valid_q[i-1];
        load_d[i]                   = load_q[i-1];
        addr_d[i*REG_AW +: REG_AW]  = addr_q[(i-1)*REG_AW +: REG_AW];
        data_d[i*DATA_W +: DATA_W]  = data_q[(i-1)*DATA_W +: DATA_W];
        // A load's result becomes available as it leaves entry 0.
        if (i == 1 && load_q[0]) begin
          load_d[i]                  = 1'b0;
          data_d[i*DATA_W +: DATA_W] = ld_data_i;
        end
      end
    end
  end

  // Count cycles that actually used a bypass path, sticking at all-ones.
  always_comb begin
    any_fwd = |fwd_sel_o;
    cnt_d   = cnt_q;
    if (any_fwd && !stall_i && (cnt_q != 16'hFFFF)) begin
      cnt_d = cnt_q + 16'd1;
    end
  end

  // History and counter registers.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      valid_q <= '0;
      load_q  <= '0;
      addr_q  <= '0;
      data_q  <= '0;
      cnt_q   <= '0;
    end else begin
      valid_q <= valid_d;
      load_q  <= load_d;
      addr_q  <= addr_d;
      data_q  <= data_d;
      cnt_q   <= cnt_d;
    end
  end

  for (genvar k = 0; k < NRD; k++) begin : g_port
    bypass_match #(
      .DATA_W (DATA_W),
      .REG_AW (REG_AW),
      .DEPTH  (DEPTH)
    ) u_match (
      .rd_addr_i    (rd_addr_i[k*REG_AW +: REG_AW]),
      .rf_data_i    (rf_data_i[k*DATA_W +: DATA_W]),
      .hist_valid_i (valid_q),
      .hist_load_i  (load_q),
      .hist_addr_i  (addr_q),
      .hist_data_i  (data_q),
      .rd_data_o    (rd_data_o[k*DATA_W +: DATA_W]),
      .fwd_sel_o    (fwd_sel_o[k*2 +: 2]),
      .hazard_o     (port_hazard[k])
    );
  end

  assign hazard_o  = |port_hazard;
  assign fwd_cnt_o = cnt_q;

endmodule

// File: tb/tb_bypass_unit.sv
// Directed bench for bypass_unit with default sizing (32-bit data, 2 entries, 2 ports).
module tb_bypass_unit;

  logic        clk;
  logic        rst_n;
  logic        wr_en;
  logic        wr_load;
  logic [4:0]  wr_addr;
  logic [31:0] wr_data;
  logic [31:0] ld_data;
  logic        stall;
  logic        flush;
  logic [9:0]  rd_addr;
  logic [63:0] rf_data;
  logic [63:0] rd_data;
  logic [3:0]  fwd_sel;
  logic        hazard;
  logic [15:0] fwd_cnt;

  int checks = 0;
  int errors = 0;

  bypass_unit dut (
    .clk_i     (clk),
    .rst_n_i   (rst_n),
    .wr_en_i   (wr_en),
    .wr_load_i (wr_load),
    .wr_addr_i (wr_addr),
    .wr_data_i (wr_data),
    .ld_data_i (ld_data),
    .stall_i   (stall),
    .flush_i   (flush),
    .rd_addr_i (rd_addr),
    .rf_data_i (rf_data),
    .rd_data_o (rd_data),
    .fwd_sel_o (fwd_sel),
    .hazard_o  (hazard),
    .fwd_cnt_o (fwd_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst_n   = 1'b0;
    wr_en   = 1'b0;
    wr_load = 1'b0;
    wr_addr = '0;
    wr_data = '0;
    ld_data = '0;
    stall   = 1'b0;
    flush   = 1'b0;
    rd_addr = '0;
    rf_data = {32'hBBBB_0001, 32'hAAAA_0000};
    #3;
    check("rst_rd_data", rd_data, rf_data);
    check("rst_fwd_sel", fwd_sel, 4'h0);
    check("rst_hazard", hazard, 1'b0);
    check("rst_cnt", fwd_cnt, 16'h0);
    step();
    rst_n = 1'b1;

    // Back-to-back writes to r5: youngest must win.
    wr_en = 1'b1; wr_addr = 5'd5; wr_data = 32'h11;
    step();
    wr_data = 32'h22;
    step();
    wr_en = 1'b0;
    rd_addr = {5'd6, 5'd5};
    #1;
    check("young_p0_data", rd_data[31:0], 32'h22);
    check("young_p0_sel", fwd_sel[1:0], 2'd1);
    check("young_p1_data", rd_data[63:32], 32'hBBBB_0001);
    check("young_p1_sel", fwd_sel[3:2], 2'd0);
    check("young_cnt", fwd_cnt, 16'd0);
    step();
    check("e1_p0_data", rd_data[31:0], 32'h22);
    check("e1_p0_sel", fwd_sel[1:0], 2'd2);
    check("e1_cnt", fwd_cnt, 16'd1);

    // Load to r7, then consumer reads it the next cycle.
    rd_addr = '0;
    wr_en = 1'b1; wr_load = 1'b1; wr_addr = 5'd7; wr_data = 32'hDEAD;
    step();
    wr_en = 1'b0; wr_load = 1'b0;
    rd_addr = {5'd7, 5'd0};
    #1;
    check("ld_hazard", hazard, 1'b1);
    check("ld_p1_sel", fwd_sel[3:2], 2'd0);
    check("ld_p1_data", rd_data[63:32], 32'hBBBB_0001);
    // Bubble cycle: the load result arrives as it moves to entry 1.
    ld_data = 32'hABCD;
    step();
    check("ldfwd_p1_data", rd_data[63:32], 32'hABCD);
    check("ldfwd_p1_sel", fwd_sel[3:2], 2'd2);
    check("ldfwd_hazard", hazard, 1'b0);
    check("ldfwd_cnt", fwd_cnt, 16'd1);
    ld_data = 32'h0;
    stall = 1'b1;
    step();
    check("stall_p1_data", rd_data[63:32], 32'hABCD);
    check("stall_p1_sel", fwd_sel[3:2], 2'd2);
    check("stall_cnt", fwd_cnt, 16'd1);
    stall = 1'b0;
    step();
    check("age_out_cnt", fwd_cnt, 16'd2);
    check("age_out_p1_data", rd_data[63:32], 32'hBBBB_0001);
    check("age_out_p1_sel", fwd_sel[3:2], 2'd0);

    // Writes to r0 are never forwarded.
    rd_addr = '0;
    rf_data = {32'hBBBB_0001, 32'h0};
    wr_en = 1'b1; wr_addr = 5'd0; wr_data = 32'hFFFF_FFFF;
    step();
    wr_en = 1'b0;
    #1;
    check("r0_p0_data", rd_data[31:0], 32'h0);
    check("r0_sel", fwd_sel, 4'h0);

    // Flush overrides a simultaneous stall.
    rf_data = {32'hBBBB_0001, 32'h1234_5678};
    wr_en = 1'b1; wr_addr = 5'd3; wr_data = 32'h5;
    step();
    wr_en = 1'b0;
    rd_addr = {5'd0, 5'd3};
    #1;
    check("pre_flush_p0_data", rd_data[31:0], 32'h5);
    check("pre_flush_p0_sel", fwd_sel[1:0], 2'd1);
    stall = 1'b1; flush = 1'b1;
    wr_en = 1'b1; wr_addr = 5'd3; wr_data = 32'h9;
    step();
    stall = 1'b0; flush = 1'b0; wr_en = 1'b0;
    #1;
    check("flush_p0_data", rd_data[31:0], 32'h1234_5678);
    check("flush_p0_sel", fwd_sel[1:0], 2'd0);
    check("flush_cnt", fwd_cnt, 16'd2);

    // Asynchronous reset mid-cycle with live history.
    rd_addr = '0;
    wr_en = 1'b1; wr_addr = 5'd9; wr_data = 32'h99;
    step();
    wr_en = 1'b0;
    rd_addr = {5'd9, 5'd0};
    #1;
    check("pre_rst_p1_data", rd_data[63:32], 32'h99);
    check("pre_rst_p1_sel", fwd_sel[3:2], 2'd1);
    #2;
    rst_n = 1'b0;
    #1;
    check("async_rst_data", rd_data, rf_data);
    check("async_rst_sel", fwd_sel, 4'h0);
    check("async_rst_hazard", hazard, 1'b0);
    check("async_rst_cnt", fwd_cnt, 16'h0);
    #2;
    rst_n = 1'b1;
    #1;
    check("post_rst_p1_data", rd_data[63:32], 32'hBBBB_0001);
    step();
    check("post_rst_step_data", rd_data[63:32], 32'hBBBB_0001);
    check("post_rst_step_sel", fwd_sel, 4'h0);

    // Counter saturation: forward r1 every cycle.
    rd_addr = {5'd0, 5'd1};
    wr_en = 1'b1; wr_addr = 5'd1; wr_data = 32'h77;
    step();
    check("sat_start_cnt", fwd_cnt, 16'd0);
    check("sat_start_sel", fwd_sel[1:0], 2'd1);
    check("sat_start_data", rd_data[31:0], 32'h77);
    repeat (16'hFFFE) step();
    check("sat_fffe", fwd_cnt, 16'hFFFE);
    repeat (2) step();
    check("sat_ffff", fwd_cnt, 16'hFFFF);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/bypass_unit.md
BYPASS_UNIT -- requirements
Module: bypass_unit

Interface
REQ-001 Parameter DATA_W, default 32: width of the data path.
REQ-002 Parameter REG_AW, default 5: width of a register address.
REQ-003 Parameter DEPTH, default 2: number of in-flight write stages tracked (minimum 1).
REQ-004 Parameter NRD, default 2: number of read ports.
REQ-005 clk_i  in  1  single clock; all state updates on rising edge.
REQ-006 rst_n_i  in  1  reset, asynchronous assert, active-low.
REQ-007 wr_en_i  in  1  the instruction entering history writes a register.
REQ-008 wr_load_i  in  1  the entering write is a load; its data is not yet available.
REQ-009 wr_addr_i  in  REG_AW  destination register of the entering write.
REQ-010 wr_data_i  in  DATA_W  result of the entering write; ignored when wr_load_i=1.
REQ-011 ld_data_i  in  DATA_W  load result; fills entry 1 when it advances from entry 0 as a load.
REQ-012 stall_i  in  1  freeze history.
REQ-013 flush_i  in  1  invalidate all history entries.
REQ-014 rd_addr_i  in  NRD*REG_AW  read addresses, port k at bits [k*REG_AW +: REG_AW].
REQ-015 rf_data_i  in  NRD*DATA_W  register-file read data per port.
REQ-016 rd_data_o  out  NRD*DATA_W  forwarded operand per port.
REQ-017 fwd_sel_o  out  NRD*2  per port source: 0 register file, 1 entry 0, 2 entry 1, 3 deeper entry.
REQ-018 hazard_o  out  1  load-use hazard; pipeline must stall one cycle.
REQ-019 fwd_cnt_o  out  16  saturating count of cycles with at least one forwarded port.

Function
REQ-020 History SHALL be DEPTH entries {valid, load, addr, data}; entry 0 youngest.
REQ-021 When stall_i=0 and flush_i=0, each edge SHALL shift entry i to i+1 and load entry 0 from wr_* inputs.
REQ-022 Entry 0 valid SHALL be wr_en_i AND (wr_addr_i != 0); register 0 is never forwarded.
REQ-023 When an entry with load=1 shifts from 0 to 1, entry 1 data SHALL be ld_data_i and its load flag SHALL clear.
REQ-024 When stall_i=1 and flush_i=0, history SHALL hold unchanged.
REQ-025 flush_i=1 SHALL clear every valid bit on the next edge, overriding stall_i and the shift.
REQ-026 Per port, rd_data_o SHALL come combinationally from the youngest valid entry with addr equal to the port address and load=0, else from rf_data_i; zero added latency.
REQ-027 A matching entry 0 with load=1 SHALL assert hazard_o combinationally; that entry SHALL NOT be used as a source.
REQ-028 Read address 0 SHALL always select the register file.
REQ-029 fwd_cnt_o SHALL increment by 1 on each edge where any fwd_sel_o is non-zero and stall_i=0, saturating at 16'hFFFF.
REQ-030 fwd_sel_o code 3 SHALL apply to entries 2..DEPTH-1; for DEPTH=1 codes 2 and 3 SHALL never occur.

Reset
REQ-031 rst_n_i low SHALL immediately clear all valid and load bits, entry addresses and data to 0, and fwd_cnt_o to 0.
REQ-032 During reset, rd_data_o SHALL equal rf_data_i, fwd_sel_o SHALL be 0 and hazard_o SHALL be 0.
REQ-033 Reset release mid-sequence SHALL resume with empty history; no write issued before reset SHALL be forwarded.

Structure
REQ-034 Package bypass_pkg SHALL hold the fwd_sel encoding constants and the default parameter values.
REQ-035 Sub-module bypass_match (one read port: priority match over history, select and hazard outputs) SHALL be instantiated NRD times.
REQ-036 History and counter SHALL be the only sequential logic; all match logic SHALL be combinational.

Verification
REQ-037 Write r5=0x11 then r5=0x22 on consecutive cycles; read r5 -> rd_data_o=0x22, fwd_sel_o=1 (youngest wins).
REQ-038 Load to r7, read r7 next cycle -> hazard_o=1; after one stall and ld_data_i=0xABCD -> rd_data_o=0xABCD, fwd_sel_o=2, hazard_o=0.
REQ-039 Write r0=0xFFFF_FFFF; read r0 with rf_data_i=0 -> rd_data_o=0, fwd_sel_o=0.
REQ-040 Write r3=0x5, assert stall_i and flush_i together -> next cycle read r3 returns rf_data_i, fwd_sel_o=0.
REQ-041 Preload fwd_cnt_o to 0xFFFE via forwarded reads; two more forwarded cycles -> fwd_cnt_o stays 0xFFFF.
REQ-042 Assert rst_n_i low mid-cycle with history valid -> outputs immediately equal rf_data_i, fwd_cnt_o=0, without waiting for a clock edge.
